// File: rtl/mem_arbiter_ctrl.sv
// ============================================================================
// Module   : mem_arbiter_ctrl
// Brief    : Single-port shared memory with a built-in fixed-priority or
//            round-robin arbiter; one read/write per grant, ack/rvalid reply.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mem_arbiter_ctrl #(
   parameter int NUM_CH   = 4,
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int DEPTH    = 64,
   parameter int ARB_MODE = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_CH-1:0]          req,
   input  logic [NUM_CH-1:0]          rw,
   input  logic [NUM_CH*ADDR_W-1:0]   addr,
   input  logic [NUM_CH*DATA_W-1:0]   wdata,
   output logic [NUM_CH-1:0]          ack,
   output logic [NUM_CH-1:0]          rvalid,
   output logic [DATA_W-1:0]          rdata,
   output logic                       busy,
   output logic [$clog2(NUM_CH)-1:0]  grant_id,
   output logic [NUM_CH-1:0]          err
);

   localparam int c_ID_W  = $clog2(NUM_CH);
   localparam int c_CW    = c_ID_W + 1;
   localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_AX_W  = ADDR_W + 1;
   localparam logic [c_AX_W-1:0] c_DEPTH_X = c_AX_W'(DEPTH);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_ACCESS = 2'd1;
   localparam logic [1:0] c_DONE   = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_next_state;

   logic [c_ID_W-1:0]  r_rr_ptr;
   logic [c_ID_W-1:0]  r_winner;
   logic               r_rw;
   logic [c_IDX_W-1:0] r_idx;
   logic               r_in_range;
   logic [DATA_W-1:0]  r_wdata;
   logic [DATA_W-1:0]  r_rd_buf;
   logic [DATA_W-1:0]  r_mem [DEPTH];

   logic [c_ID_W-1:0]  w_base;
   logic [c_CW-1:0]    w_cand;
   logic [c_ID_W-1:0]  w_winner;
   logic [ADDR_W-1:0]  w_sel_addr;
   logic               w_in_range;
   logic               w_grant;

   logic [NUM_CH-1:0]  w_ack_nxt;
   logic [NUM_CH-1:0]  w_rvalid_nxt;
   logic [NUM_CH-1:0]  w_err_nxt;
   logic               w_busy_nxt;

   // Fixed priority is round-robin with the search base pinned to channel 0.
   assign w_base = (ARB_MODE == 1) ? r_rr_ptr : '0;

   always_comb begin
      w_winner = '0;
      w_cand   = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         w_cand = {1'b0, w_base} + c_CW'(k);
         if (w_cand >= c_CW'(NUM_CH))
            w_cand = w_cand - c_CW'(NUM_CH);
         if (req[w_cand[c_ID_W-1:0]])
            w_winner = w_cand[c_ID_W-1:0];
      end
   end

   assign w_sel_addr = addr[w_winner * ADDR_W +: ADDR_W];
   assign w_in_range = ({1'b0, w_sel_addr} < c_DEPTH_X);
   assign w_grant    = (r_state == c_IDLE) && (|req);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= c_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:   if (|req) w_next_state = c_ACCESS;
         c_ACCESS: w_next_state = c_DONE;
         c_DONE:   w_next_state = c_IDLE;
         default:  w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      w_ack_nxt    = '0;
      w_rvalid_nxt = '0;
      w_err_nxt    = '0;
      w_busy_nxt   = (w_next_state != c_IDLE);
      if (r_state == c_DONE) begin
         w_ack_nxt[r_winner]    = 1'b1;
         w_rvalid_nxt[r_winner] = ~r_rw;
         w_err_nxt[r_winner]    = ~r_in_range;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack        <= '0;
         rvalid     <= '0;
         err        <= '0;
         busy       <= 1'b0;
         rdata      <= '0;
         grant_id   <= '0;
         r_rr_ptr   <= '0;
         r_winner   <= '0;
         r_rw       <= 1'b0;
         r_idx      <= '0;
         r_in_range <= 1'b0;
         r_wdata    <= '0;
      end else begin
         ack    <= w_ack_nxt;
         rvalid <= w_rvalid_nxt;
         err    <= w_err_nxt;
         busy   <= w_busy_nxt;
         if (w_grant) begin
            r_winner   <= w_winner;
            grant_id   <= w_winner;
            r_rw       <= rw[w_winner];
            r_idx      <= w_sel_addr[c_IDX_W-1:0];
            r_in_range <= w_in_range;
            r_wdata    <= wdata[w_winner * DATA_W +: DATA_W];
         end
         if (r_state == c_DONE) begin
            r_rr_ptr <= (r_winner == c_ID_W'(NUM_CH - 1)) ? '0 : r_winner + 1'b1;
            if (!r_rw)
               rdata <= r_rd_buf;
         end
      end
   end

   // Array kept free of reset; reset forces IDLE, which blocks any access.
   always_ff @(posedge clk) begin
      if (r_state == c_ACCESS) begin
         if (r_rw && r_in_range)
            r_mem[r_idx] <= r_wdata;
         if (!r_rw)
            r_rd_buf <= r_in_range ? r_mem[r_idx] : '0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter_ctrl.sv
// ============================================================================
// Module   : tb_mem_arbiter_ctrl
// Brief    : Directed bench for mem_arbiter_ctrl, round-robin and fixed units.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter_ctrl;

   localparam int NCH = 4;
   localparam int DW  = 8;
   localparam int AW  = 8;
   localparam int DEP = 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Unit 0 is round-robin, unit 1 is fixed priority.
   logic [NCH-1:0]    req_s   [2];
   logic [NCH-1:0]    rw_s    [2];
   logic [NCH*AW-1:0] addr_s  [2];
   logic [NCH*DW-1:0] wdata_s [2];
   logic [NCH-1:0]    ack_s   [2];
   logic [NCH-1:0]    rv_s    [2];
   logic [NCH-1:0]    err_s   [2];
   logic [DW-1:0]     rdata_s [2];
   logic              busy_s  [2];
   logic [1:0]        gid_s   [2];

   mem_arbiter_ctrl #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .ARB_MODE(1)) dut_rr (
      .clk(clk), .reset(reset), .req(req_s[0]), .rw(rw_s[0]), .addr(addr_s[0]),
      .wdata(wdata_s[0]), .ack(ack_s[0]), .rvalid(rv_s[0]), .rdata(rdata_s[0]),
      .busy(busy_s[0]), .grant_id(gid_s[0]), .err(err_s[0]));

   mem_arbiter_ctrl #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .ARB_MODE(0)) dut_fp (
      .clk(clk), .reset(reset), .req(req_s[1]), .rw(rw_s[1]), .addr(addr_s[1]),
      .wdata(wdata_s[1]), .ack(ack_s[1]), .rvalid(rv_s[1]), .rdata(rdata_s[1]),
      .busy(busy_s[1]), .grant_id(gid_s[1]), .err(err_s[1]));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s unit%0d: got %0h, expected %0h (t=%0t)", nm, u, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   int            m_left [2];
   int            m_win  [2];
   bit            m_rw   [2];
   int            m_addr [2];
   logic [DW-1:0] m_wd   [2];
   int            m_ptr  [2];
   logic [DW-1:0] m_mem  [2][DEP];
   bit            m_known[2][DEP];
   logic [DW-1:0] m_rbuf [2];
   bit            m_rbk  [2];
   logic [NCH-1:0] e_ack [2];
   logic [NCH-1:0] e_rv  [2];
   logic [NCH-1:0] e_err [2];
   bit            e_busy [2];
   int            e_gid  [2];
   logic [DW-1:0] e_rdata[2];
   bit            e_rdk  [2];

   function automatic int pick(input logic [NCH-1:0] r, input int ptr, input bit rr);
      for (int k = 0; k < NCH; k++) begin
         int c;
         c = rr ? (ptr + k) % NCH : k;
         if (r[c]) return c;
      end
      return 0;
   endfunction

   always @(posedge clk or posedge reset) begin
      for (int u = 0; u < 2; u++) begin
         if (reset) begin
            m_left[u] = 0;  m_ptr[u] = 0;
            e_ack[u] = '0;  e_rv[u] = '0;  e_err[u] = '0;
            e_busy[u] = 0;  e_gid[u] = 0;  e_rdata[u] = '0;  e_rdk[u] = 1;
         end else begin
            e_ack[u] = '0;  e_rv[u] = '0;  e_err[u] = '0;
            if (m_left[u] == 0) begin
               if (req_s[u] != '0) begin
                  m_win[u]  = pick(req_s[u], m_ptr[u], (u == 0));
                  m_rw[u]   = rw_s[u][m_win[u]];
                  m_addr[u] = int'(addr_s[u][m_win[u]*AW +: AW]);
                  m_wd[u]   = wdata_s[u][m_win[u]*DW +: DW];
                  e_gid[u]  = m_win[u];
                  e_busy[u] = 1;
                  m_left[u] = 2;
               end
            end else if (m_left[u] == 2) begin
               if (m_addr[u] < DEP) begin
                  if (m_rw[u]) begin
                     m_mem[u][m_addr[u]]   = m_wd[u];
                     m_known[u][m_addr[u]] = 1;
                  end else begin
                     m_rbuf[u] = m_mem[u][m_addr[u]];
                     m_rbk[u]  = m_known[u][m_addr[u]];
                  end
               end else if (!m_rw[u]) begin
                  m_rbuf[u] = '0;
                  m_rbk[u]  = 1;
               end
               m_left[u] = 1;
            end else begin
               e_ack[u][m_win[u]] = 1'b1;
               if (m_addr[u] >= DEP) e_err[u][m_win[u]] = 1'b1;
               if (!m_rw[u]) begin
                  e_rv[u][m_win[u]] = 1'b1;
                  e_rdata[u] = m_rbuf[u];
                  e_rdk[u]   = m_rbk[u];
               end
               m_ptr[u]  = (m_win[u] + 1) % NCH;
               e_busy[u] = 0;
               m_left[u] = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b0) begin
         for (int u = 0; u < 2; u++) begin
            chk("ack",      u, 32'(ack_s[u]),  32'(e_ack[u]));
            chk("rvalid",   u, 32'(rv_s[u]),   32'(e_rv[u]));
            chk("err",      u, 32'(err_s[u]),  32'(e_err[u]));
            chk("busy",     u, 32'(busy_s[u]), 32'(e_busy[u]));
            chk("grant_id", u, 32'(gid_s[u]),  32'(e_gid[u]));
            if (e_rdk[u]) chk("rdata", u, 32'(rdata_s[u]), 32'(e_rdata[u]));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic txn(input int u, input int ch, input bit w, input logic [7:0] a,
                      input logic [7:0] d, output logic [7:0] rd, output int lat,
                      output bit e, output bit rv);
      @(negedge clk);
      req_s[u][ch]            = 1'b1;
      rw_s[u][ch]             = w;
      addr_s[u][ch*AW +: AW]  = a;
      wdata_s[u][ch*DW +: DW] = d;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ack_s[u][ch] && lat < 40);
      chk("ack_seen", u, 32'(ack_s[u][ch]), 1);
      rd = rdata_s[u];
      e  = err_s[u][ch];
      rv = rv_s[u][ch];
      req_s[u][ch] = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [7:0] rd, rd3;
      int lat, lat3, cyc, nack, nlow, ch;
      bit e, rv, e3, rv3;
      int exp_rr [5];
      int exp_fp_ch [3];
      int exp_fp_dat [3];

      exp_rr     = '{0, 1, 2, 3, 0};
      exp_fp_ch  = '{1, 1, 3};
      exp_fp_dat = '{8'hB1, 8'hB1, 8'hB3};

      reset = 1'b1;
      for (int u = 0; u < 2; u++) begin
         req_s[u] = '0; rw_s[u] = '0; addr_s[u] = '0; wdata_s[u] = '0;
      end
      repeat (2) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         chk("rst_ack",   u, 32'(ack_s[u]),   0);
         chk("rst_rv",    u, 32'(rv_s[u]),    0);
         chk("rst_err",   u, 32'(err_s[u]),   0);
         chk("rst_busy",  u, 32'(busy_s[u]),  0);
         chk("rst_gid",   u, 32'(gid_s[u]),   0);
         chk("rst_rdata", u, 32'(rdata_s[u]), 0);
      end
      reset = 1'b0;

      // single write then read on ch2
      txn(0, 0, 1, 8'h00, 8'h5A, rd, lat, e, rv);
      txn(0, 2, 1, 8'h10, 8'hA5, rd, lat, e, rv);
      chk("wr_lat", 0, lat, 3);
      txn(0, 2, 0, 8'h10, 8'h00, rd, lat, e, rv);
      chk("rd_lat", 0, lat, 3);
      chk("rd_data", 0, 32'(rd), 8'hA5);
      chk("rd_rvalid", 0, 32'(rv), 1);
      chk("rd_err", 0, 32'(e), 0);

      // ch3 read queued one cycle behind ch0 write to the same word
      fork
         txn(0, 0, 1, 8'h05, 8'h3C, rd, lat, e, rv);
         begin
            @(negedge clk);
            txn(0, 3, 0, 8'h05, 8'h00, rd3, lat3, e3, rv3);
         end
      join
      chk("coh_data", 0, 32'(rd3), 8'h3C);
      chk("coh_rvalid", 0, 32'(rv3), 1);
      chk("coh_lat", 0, lat3, 5);

      // out-of-range write/read; addr 64 must not alias onto addr 0
      txn(0, 1, 1, 8'd64, 8'hFF, rd, lat, e, rv);
      chk("oor_wr_err", 0, 32'(e), 1);
      chk("oor_wr_lat", 0, lat, 3);
      txn(0, 1, 0, 8'd64, 8'h00, rd, lat, e, rv);
      chk("oor_rd_err", 0, 32'(e), 1);
      chk("oor_rd_data", 0, 32'(rd), 0);
      txn(0, 1, 0, 8'd0, 8'h00, rd, lat, e, rv);
      chk("addr0_data", 0, 32'(rd), 8'h5A);
      chk("addr0_err", 0, 32'(e), 0);

      // round-robin with all channels reading continuously from reset
      for (int i = 0; i < NCH; i++)
         txn(0, i, 1, 8'(8'h20 + i), 8'(8'hC0 + i), rd, lat, e, rv);
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         rw_s[0][i] = 1'b0;
         addr_s[0][i*AW +: AW] = 8'(8'h20 + i);
      end
      req_s[0] = '1;
      cyc = 0; nack = 0; nlow = 0;
      while (nack < 5 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (!busy_s[0]) nlow++;
         if (ack_s[0] != '0) begin
            ch = 0;
            for (int i = 0; i < NCH; i++) if (ack_s[0][i]) ch = i;
            chk("rr_order", 0, ch, exp_rr[nack]);
            chk("rr_time", 0, cyc, 3 * (nack + 1));
            chk("rr_data", 0, 32'(rdata_s[0]), 32'(8'hC0 + exp_rr[nack]));
            nack++;
         end
      end
      req_s[0] = '0;
      chk("rr_acks", 0, nack, 5);
      chk("rr_busy_low", 0, nlow, 5);

      // reset during ACCESS of a ch0 write
      txn(0, 0, 1, 8'h07, 8'h11, rd, lat, e, rv);
      @(negedge clk);
      req_s[0][0] = 1'b1; rw_s[0][0] = 1'b1;
      addr_s[0][0 +: AW] = 8'h07; wdata_s[0][0 +: DW] = 8'h77;
      @(posedge clk);
      #1 chk("mid_busy", 0, 32'(busy_s[0]), 1);
      #1 reset = 1'b1;
      #1;
      chk("abort_ack", 0, 32'(ack_s[0]), 0);
      chk("abort_busy", 0, 32'(busy_s[0]), 0);
      chk("abort_gid", 0, 32'(gid_s[0]), 0);
      req_s[0][0] = 1'b0;
      @(negedge clk) reset = 1'b0;
      txn(0, 0, 0, 8'h07, 8'h00, rd, lat, e, rv);
      chk("abort_mem", 0, 32'(rd), 8'h11);

      // fixed priority: ch1 holds req and wins twice before ch3
      txn(1, 1, 1, 8'h20, 8'hB1, rd, lat, e, rv);
      txn(1, 3, 1, 8'h30, 8'hB3, rd, lat, e, rv);
      @(negedge clk);
      rw_s[1][1] = 1'b0; addr_s[1][1*AW +: AW] = 8'h20; req_s[1][1] = 1'b1;
      rw_s[1][3] = 1'b0; addr_s[1][3*AW +: AW] = 8'h30; req_s[1][3] = 1'b1;
      cyc = 0; nack = 0;
      while (nack < 3 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (cyc <= 6) chk("fp_gid", 1, 32'(gid_s[1]), 1);
         if (ack_s[1] != '0) begin
            ch = 0;
            for (int i = 0; i < NCH; i++) if (ack_s[1][i]) ch = i;
            chk("fp_order", 1, ch, exp_fp_ch[nack]);
            chk("fp_time", 1, cyc, 3 * (nack + 1));
            chk("fp_data", 1, 32'(rdata_s[1]), 32'(exp_fp_dat[nack]));
            nack++;
            if (nack == 2) req_s[1][1] = 1'b0;
            if (nack == 3) req_s[1][3] = 1'b0;
         end
      end
      req_s[1] = '0;
      chk("fp_acks", 1, nack, 3);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
